// File: rtl/adf4158_cfg.sv
// adf4158_cfg: loads ten 32-bit words into an ADF4158 over its 3-wire bus after enable.
// Optional lock wait: define ADF4158_LOCK_WAIT_EN to hold config_done until MUXOUT lock.
//
// Ports:
//   clk         system clock, sole clock domain
//   rst_n       asynchronous active-low reset
//   enable      level-sensitive start/hold; low aborts to idle on the next edge
//   muxout      ADF4158 MUXOUT lock detect (used only with ADF4158_LOCK_WAIT_EN)
//   config_done high once every word is written (and lock seen, if enabled)
//   ce          chip enable
//   le          load enable, high pulse latches the shifted word
//   sclk        serial clock
//   data        serial data, MSB first
//   txdata      ramp trigger, held low
module adf4158_cfg #(
    parameter int unsigned SCLK_HALF = 1,
    parameter int unsigned CE_WAIT   = 16,
    parameter logic [31:0] WORD0     = 32'h0000_0007,
    parameter logic [31:0] WORD1     = 32'h0000_A006,
    parameter logic [31:0] WORD2     = 32'h0080_A006,
    parameter logic [31:0] WORD3     = 32'h0012_4C85,
    parameter logic [31:0] WORD4     = 32'h0092_4C85,
    parameter logic [31:0] WORD5     = 32'h0018_C804,
    parameter logic [31:0] WORD6     = 32'h0000_0443,
    parameter logic [31:0] WORD7     = 32'h0740_8012,
    parameter logic [31:0] WORD8     = 32'h1234_5679,
    parameter logic [31:0] WORD9     = 32'hF812_0000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic muxout,
    output logic config_done,
    output logic ce,
    output logic le,
    output logic sclk,
    output logic data,
    output logic txdata
);

`ifdef ADF4158_LOCK_WAIT_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_CE_WAIT,
        S_SHIFT,
        S_LATCH,
        S_GAP,
        S_DONE,
        S_WAIT_LOCK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_CE_WAIT,
        S_SHIFT,
        S_LATCH,
        S_GAP,
        S_DONE
    } state_t;
`endif

    // One counter serves the CE settle time and every 2*SCLK_HALF
    // slot (one bit, the LE pulse, the inter-word gap).
    localparam int unsigned CNT_MAX =
        (CE_WAIT > 2 * SCLK_HALF) ? CE_WAIT : 2 * SCLK_HALF;
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CE_LAST  = CW'(CE_WAIT - 1);
    localparam logic [CW-1:0] SLOT_END = CW'(2 * SCLK_HALF - 1);
    localparam logic [CW-1:0] HALF     = CW'(SCLK_HALF);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    LAST_WRD = 4'd9;

    state_t        state_q, state_d;
    logic [3:0]    word_q, word_d;
    logic [4:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic ce_q, ce_d;
    logic le_q, le_d;
    logic sclk_q, sclk_d;
    logic data_q, data_d;
    logic done_q, done_d;

    logic [31:0] cur_word;

    function automatic logic [31:0] word_at(input logic [3:0] idx);
        logic [31:0] w;
        w = '0;
        case (idx)
            4'd0:    w = WORD0;
            4'd1:    w = WORD1;
            4'd2:    w = WORD2;
            4'd3:    w = WORD3;
            4'd4:    w = WORD4;
            4'd5:    w = WORD5;
            4'd6:    w = WORD6;
            4'd7:    w = WORD7;
            4'd8:    w = WORD8;
            4'd9:    w = WORD9;
            default: w = '0;
        endcase
        return w;
    endfunction

`ifdef ADF4158_LOCK_WAIT_EN
    logic lock_s1_q, lock_s1_d;
    logic lock_s2_q, lock_s2_d;

    always_comb begin
        lock_s1_d = muxout;
        lock_s2_d = lock_s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= lock_s1_d;
            lock_s2_q <= lock_s2_d;
        end
    end
`else
    logic unused_muxout;
    assign unused_muxout = muxout;
`endif

    // Next-state logic. Dropping enable wins over everything so an
    // aborted word never reaches its LE pulse.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;

        if (!enable) begin
            state_d = S_IDLE;
            word_d  = '0;
            bit_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_CE_WAIT;
                    word_d  = '0;
                    bit_d   = '0;
                    cnt_d   = '0;
                end
                S_CE_WAIT: begin
                    if (cnt_q == CE_LAST) begin
                        state_d = S_SHIFT;
                        word_d  = '0;
                        bit_d   = 5'd31;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == SLOT_END) begin
                        cnt_d = '0;
                        if (bit_q == 5'd0) begin
                            state_d = S_LATCH;
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_LATCH: begin
                    if (cnt_q == SLOT_END) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_q == SLOT_END) begin
                        cnt_d = '0;
                        if (word_q == LAST_WRD) begin
`ifdef ADF4158_LOCK_WAIT_EN
                            state_d = S_WAIT_LOCK;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_SHIFT;
                            word_d  = word_q + 4'd1;
                            bit_d   = 5'd31;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`ifdef ADF4158_LOCK_WAIT_EN
                S_WAIT_LOCK: begin
                    if (lock_s2_q) begin
                        state_d = S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                    word_d  = '0;
                    bit_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so every pin changes
    // on the same edge as the state, glitch-free. The first half of
    // each bit slot keeps sclk low while data settles.
    always_comb begin
        cur_word = word_at(word_d);
        ce_d     = (state_d != S_IDLE);
        le_d     = (state_d == S_LATCH);
        sclk_d   = (state_d == S_SHIFT) && (cnt_d >= HALF);
        data_d   = (state_d == S_SHIFT) ? cur_word[bit_d] : 1'b0;
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            le_q    <= 1'b0;
            sclk_q  <= 1'b0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            le_q    <= le_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign ce          = ce_q;
    assign le          = le_q;
    assign sclk        = sclk_q;
    assign data        = data_q;
    assign config_done = done_q;
    assign txdata      = 1'b0;

endmodule

// File: tb/tb_adf4158_cfg.sv
// tb_adf4158_cfg: self-checking bench for adf4158_cfg at SCLK_HALF 1 and 3.
// Table vectors, hand sequences and random enable/reset against a timing model.
module tb_adf4158_cfg;

    localparam logic [31:0] W [10] = '{
        32'h0000_0007, 32'h0000_A006, 32'h0080_A006, 32'h0012_4C85,
        32'h0092_4C85, 32'h0018_C804, 32'h0000_0443, 32'h0740_8012,
        32'h1234_5679, 32'hF812_0000
    };
    localparam int HS [2] = '{1, 3};
    localparam int CEW = 16;
`ifdef ADF4158_LOCK_WAIT_EN
    localparam int DL = 1;
`else
    localparam int DL = 0;
`endif

    typedef struct packed {
        logic ce;
        logic le;
        logic sclk;
        logic data;
        logic done;
        logic tx;
    } outs_t;

    typedef struct {
        int    k;
        int    d;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic muxout = 1'b1;
    logic ce_o [2];
    logic le_o [2];
    logic sclk_o [2];
    logic data_o [2];
    logic done_o [2];
    logic tx_o [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        adf4158_cfg #(
            .SCLK_HALF(HS[g]), .CE_WAIT(CEW),
            .WORD0(W[0]), .WORD1(W[1]), .WORD2(W[2]), .WORD3(W[3]),
            .WORD4(W[4]), .WORD5(W[5]), .WORD6(W[6]), .WORD7(W[7]),
            .WORD8(W[8]), .WORD9(W[9])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .enable(enable), .muxout(muxout),
            .config_done(done_o[g]), .ce(ce_o[g]), .le(le_o[g]),
            .sclk(sclk_o[g]), .data(data_o[g]), .txdata(tx_o[g])
        );
    end

    int checks = 0;
    int errors = 0;
    bit active = 1'b0;
    int k = 0;
    bit chk_model = 1'b1;

    int nrise [2];
    int npulse [2];
    int badlen [2];
    int lelen [2];
    int done_k [2];
    logic [31:0] shreg [2];
    logic [31:0] cap [2][10];
    logic sclk_p [2];
    logic done_p [2];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h k=%0d t=%0t",
                     name, act, exp, k, $time);
        end
    endtask

    function automatic outs_t sample(int d);
        outs_t o;
        o = '{ce_o[d], le_o[d], sclk_o[d], data_o[d], done_o[d], tx_o[d]};
        return o;
    endfunction

    function automatic outs_t mk(bit c, bit l, bit s, bit dt, bit dn);
        outs_t o;
        o = '{c, l, s, dt, dn, 1'b0};
        return o;
    endfunction

    function automatic logic wb(int w, int b);
        logic [31:0] t;
        t = W[w];
        return t[b];
    endfunction

    // Expected pins k edges after enable was first sampled high:
    // CEW cycles of settle, then ten 68*h words (64*h shift, 2*h LE,
    // 2*h gap), then done.
    function automatic outs_t model(int h, int kk);
        outs_t o;
        int j, w, r;
        logic [31:0] wv;
        o = '0;
        o.ce = 1'b1;
        if (kk < CEW) return o;
        j = kk - CEW;
        if (j >= 680 * h + DL) begin
            o.done = 1'b1;
            return o;
        end
        if (j >= 680 * h) return o;
        w = j / (68 * h);
        r = j % (68 * h);
        if (r < 64 * h) begin
            wv = W[w];
            o.sclk = ((r % (2 * h)) >= h);
            o.data = wv[31 - r / (2 * h)];
        end else if (r < 66 * h) begin
            o.le = 1'b1;
        end
        return o;
    endfunction

    task automatic mon_clear();
        for (int d = 0; d < 2; d++) begin
            nrise[d] = 0;
            npulse[d] = 0;
            badlen[d] = 0;
            lelen[d] = 0;
            done_k[d] = -1;
            shreg[d] = '0;
            sclk_p[d] = 1'b0;
            done_p[d] = 1'b0;
            for (int i = 0; i < 10; i++) cap[d][i] = '0;
        end
    endtask

    task automatic step();
        outs_t a, e;
        @(posedge clk);
        if (!rst_n) active = 1'b0;
        else if (enable) begin
            if (active) k++;
            else begin
                active = 1'b1;
                k = 0;
            end
        end else active = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            a = sample(d);
            e = active ? model(HS[d], k) : '0;
            if (chk_model)
                check($sformatf("cycle_dut%0d", d), 32'(a), 32'(e));
            if (a.sclk && !sclk_p[d]) begin
                shreg[d] = {shreg[d][30:0], a.data};
                if (nrise[d] % 32 == 31 && nrise[d] < 320)
                    cap[d][nrise[d] / 32] = shreg[d];
                nrise[d]++;
            end
            if (a.le) lelen[d]++;
            else if (lelen[d] != 0) begin
                npulse[d]++;
                if (lelen[d] != 2 * HS[d]) badlen[d]++;
                lelen[d] = 0;
            end
            if (a.done && !done_p[d] && done_k[d] < 0) done_k[d] = k;
            sclk_p[d] = a.sclk;
            done_p[d] = a.done;
        end
`ifndef ADF4158_LOCK_WAIT_EN
        muxout = 1'($urandom);
`endif
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic run_until(int kt, string name);
        int i;
        i = 0;
        while (!(active && k >= kt) && i < 5000) begin
            step();
            i++;
        end
        check({name, "_reach"}, 32'(k), 32'(kt));
    endtask

    task automatic check_words(int d, string name);
        for (int i = 0; i < 10; i++)
            check($sformatf("%s_word%0d", name, i), cap[d][i], W[i]);
        check({name, "_rises"}, 32'(nrise[d]), 32'd320);
    endtask

    vec_t tbl [$];

    initial begin
        tbl.push_back('{0,    0, mk(1, 0, 0, 0, 0)});
        tbl.push_back('{15,   0, mk(1, 0, 0, 0, 0)});
        tbl.push_back('{16,   0, mk(1, 0, 0, wb(0, 31), 0)});
        tbl.push_back('{16,   1, mk(1, 0, 0, wb(0, 31), 0)});
        tbl.push_back('{17,   0, mk(1, 0, 1, wb(0, 31), 0)});
        tbl.push_back('{18,   1, mk(1, 0, 0, wb(0, 31), 0)});
        tbl.push_back('{19,   1, mk(1, 0, 1, wb(0, 31), 0)});
        tbl.push_back('{22,   1, mk(1, 0, 0, wb(0, 30), 0)});
        tbl.push_back('{78,   0, mk(1, 0, 0, wb(0, 0), 0)});
        tbl.push_back('{79,   0, mk(1, 0, 1, wb(0, 0), 0)});
        tbl.push_back('{80,   0, mk(1, 1, 0, 0, 0)});
        tbl.push_back('{81,   0, mk(1, 1, 0, 0, 0)});
        tbl.push_back('{82,   0, mk(1, 0, 0, 0, 0)});
        tbl.push_back('{84,   0, mk(1, 0, 0, wb(1, 31), 0)});
        tbl.push_back('{208,  1, mk(1, 1, 0, 0, 0)});
        tbl.push_back('{213,  1, mk(1, 1, 0, 0, 0)});
        tbl.push_back('{214,  1, mk(1, 0, 0, 0, 0)});
        tbl.push_back('{628,  0, mk(1, 0, 0, wb(9, 31), 0)});
        tbl.push_back('{629,  0, mk(1, 0, 1, wb(9, 31), 0)});
        tbl.push_back('{695,  0, mk(1, 0, 0, 0, 0)});
        tbl.push_back('{696 + DL, 0, mk(1, 0, 0, 0, 1)});
        tbl.push_back('{2055, 1, mk(1, 0, 0, 0, 0)});
        tbl.push_back('{2056 + DL, 1, mk(1, 0, 0, 0, 1)});

        mon_clear();
        #3;
        for (int d = 0; d < 2; d++)
            check($sformatf("reset_dut%0d", d), 32'(sample(d)), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(3);

        // Full sequence on both instances through the vector table.
        mon_clear();
        enable = 1'b1;
        foreach (tbl[i]) begin
            run_until(tbl[i].k, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_dut%0d", i, tbl[i].d),
                  32'(sample(tbl[i].d)), 32'(tbl[i].exp));
        end
        run(4);
        for (int d = 0; d < 2; d++) begin
            check_words(d, $sformatf("full_dut%0d", d));
            check($sformatf("le_pulses_dut%0d", d), 32'(npulse[d]), 32'd10);
            check($sformatf("le_len_dut%0d", d), 32'(badlen[d]), 32'd0);
            check($sformatf("done_at_dut%0d", d), 32'(done_k[d]),
                  32'(CEW + 680 * HS[d] + DL));
        end

        // Abort during word 4 bit 10 of the fast instance.
        enable = 1'b0;
        run(2);
        mon_clear();
        enable = 1'b1;
        run_until(CEW + 4 * 68 + 42, "abort");
        check("abort_pre_pulses", 32'(npulse[0]), 32'd4);
        enable = 1'b0;
        step();
        check("abort_outs", 32'(sample(0)), 32'd0);
        run(6);
        check("abort_no_le", 32'(npulse[0] + lelen[0]), 32'd4);
        mon_clear();
        enable = 1'b1;
        run_until(CEW + 680 + DL + 2, "restart");
        check_words(0, "restart");
        check("restart_done_at", 32'(done_k[0]), 32'(CEW + 680 + DL));

        // Asynchronous reset while done.
        #2 rst_n = 1'b0;
        #1;
        check("rst_done_fall", {31'd0, done_o[0]}, 32'd0);
        check("rst_done_ce", {31'd0, ce_o[0]}, 32'd0);
        run(2);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of the first LE pulse.
        run_until(CEW + 65, "latch");
        check("latch_le_pre", {31'd0, le_o[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("latch_rst_le", {31'd0, le_o[0]}, 32'd0);
        check("latch_rst_ce", {31'd0, ce_o[0]}, 32'd0);
        check("latch_rst_done", {31'd0, done_o[0]}, 32'd0);
        check("latch_rst_tx", {31'd0, tx_o[0]}, 32'd0);
        run(2);
        rst_n = 1'b1;

        // Random enable windows and reset pulses.
        for (int s = 0; s < 14; s++) begin
            enable = 1'b1;
            if ($urandom_range(0, 2) == 0) run($urandom_range(2100, 2300));
            else run($urandom_range(1, 900));
            enable = 1'b0;
            run($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'($urandom);
                #($urandom_range(1, 3)) rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end

`ifdef ADF4158_LOCK_WAIT_EN
        // Lock wait: no done until synchronised MUXOUT goes high.
        enable = 1'b0;
        run(2);
        chk_model = 1'b0;
        muxout = 1'b0;
        enable = 1'b1;
        run_until(CEW + 680, "lock");
        for (int i = 0; i < 1000; i++) begin
            step();
            check("lock_wait_done", {31'd0, done_o[0]}, 32'd0);
        end
        check("lock_wait_ce", {31'd0, ce_o[0]}, 32'd1);
        muxout = 1'b1;
        for (int i = 0; i < 3 && !done_o[0]; i++) step();
        check("lock_done", {31'd0, done_o[0]}, 32'd1);
        muxout = 1'b0;
        run(5);
        check("lock_done_hold", {31'd0, done_o[0]}, 32'd1);
        chk_model = 1'b1;
`endif

        enable = 1'b0;
        run(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
